// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and encodings for the multicycle control unit
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC_R,
      ST_EXEC_I,
      ST_EXEC_LUI,
      ST_WB_ALU,
      ST_MEM_ADDR,
      ST_MEM_LD,
      ST_WB_MEM,
      ST_MEM_SD,
      ST_BRANCH,
      ST_JALR,
      ST_HALT,
      ST_ILLEGAL
   } state_e;

   typedef enum logic [2:0] {
      CLS_ALU_R,
      CLS_ALU_I,
      CLS_LUI,
      CLS_MEM,
      CLS_BRANCH,
      CLS_JALR,
      CLS_EBREAK,
      CLS_ILLEGAL
   } insn_class_e;

   localparam logic [6:0]  OPC_OP      = 7'b0110011;
   localparam logic [6:0]  OPC_OP_IMM  = 7'b0010011;
   localparam logic [6:0]  OPC_LUI     = 7'b0110111;
   localparam logic [6:0]  OPC_LOAD    = 7'b0000011;
   localparam logic [6:0]  OPC_STORE   = 7'b0100011;
   localparam logic [6:0]  OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0]  OPC_JALR    = 7'b1100111;
   localparam logic [6:0]  OPC_SYSTEM  = 7'b1110011;

   localparam logic [2:0]  F3_ADD      = 3'b000;
   localparam logic [2:0]  F3_DWORD    = 3'b011;
   localparam logic [2:0]  F3_BEQ      = 3'b000;
   localparam logic [2:0]  F3_BNE      = 3'b001;
   localparam logic [6:0]  F7_ADD      = 7'b0000000;
   localparam logic [6:0]  F7_SUB      = 7'b0100000;
   localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

   typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_PASS_B = 2'd2} alu_op_e;
   typedef enum logic [1:0] {PC_SRC_ALU = 2'd0, PC_SRC_ALUOUT = 2'd1, PC_SRC_JALR = 2'd2} pc_src_e;
   typedef enum logic [1:0] {WB_ALUOUT = 2'd0, WB_MDR = 2'd1, WB_PC = 2'd2} wb_sel_e;
   typedef enum logic [1:0] {SRC_A_PC = 2'd0, SRC_A_REG = 2'd1, SRC_A_OLD_PC = 2'd2} alu_src_a_e;
   typedef enum logic [1:0] {SRC_B_REG = 2'd0, SRC_B_FOUR = 2'd1, SRC_B_IMM = 2'd2} alu_src_b_e;

endpackage

// File: rtl/insn_class_decode.sv
// rtl/insn_class_decode.sv - combinational instruction classifier for the DECODE dispatch
module insn_class_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [31:0] instr_i,
   output insn_class_e insn_class_o
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];

   always_comb begin
      insn_class_o = CLS_ILLEGAL;
      case (opcode)
         OPC_OP: begin
            if (funct3 == F3_ADD && (funct7 == F7_ADD || funct7 == F7_SUB))
               insn_class_o = CLS_ALU_R;
         end
         OPC_OP_IMM: begin
            if (funct3 == F3_ADD)
               insn_class_o = CLS_ALU_I;
         end
         OPC_LUI:   insn_class_o = CLS_LUI;
         OPC_LOAD, OPC_STORE: begin
            if (funct3 == F3_DWORD)
               insn_class_o = CLS_MEM;
         end
         OPC_BRANCH: begin
            if (funct3 == F3_BEQ || funct3 == F3_BNE)
               insn_class_o = CLS_BRANCH;
         end
         OPC_JALR: begin
            if (funct3 == F3_ADD)
               insn_class_o = CLS_JALR;
         end
         OPC_SYSTEM: begin
            // Only the exact ebreak encoding halts; other SYSTEM forms are unsupported.
            if (instr_i == INSN_EBREAK)
               insn_class_o = CLS_EBREAK;
         end
         default: insn_class_o = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - Moore multicycle control FSM with memory wait pacing
module multicycle_ctrl_fsm
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        alu_zero,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        ir_write,
   output logic        mem_addr_sel,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mdr_write,
   output logic        ab_write,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic        alu_out_write,
   output logic        reg_write,
   output logic [1:0]  wb_sel,
   output logic        halted,
   output logic        illegal_op
);

   localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   insn_class_e insn_class;
   logic        is_mem_state;
   logic        mem_last;

   insn_class_decode u_decode (
      .instr_i      (instr),
      .insn_class_o (insn_class)
   );

   assign is_mem_state = (state_q == ST_FETCH) || (state_q == ST_MEM_LD) || (state_q == ST_MEM_SD);
   assign mem_last     = (cnt_q == WAIT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      if (is_mem_state && !mem_last)
         cnt_d = cnt_q + 3'd1;
      case (state_q)
         ST_FETCH:    if (mem_last) state_d = ST_DECODE;
         ST_DECODE: begin
            case (insn_class)
               CLS_ALU_R:  state_d = ST_EXEC_R;
               CLS_ALU_I:  state_d = ST_EXEC_I;
               CLS_LUI:    state_d = ST_EXEC_LUI;
               CLS_MEM:    state_d = ST_MEM_ADDR;
               CLS_BRANCH: state_d = ST_BRANCH;
               CLS_JALR:   state_d = ST_JALR;
               CLS_EBREAK: state_d = ST_HALT;
               default:    state_d = ST_ILLEGAL;
            endcase
         end
         ST_EXEC_R, ST_EXEC_I, ST_EXEC_LUI: state_d = ST_WB_ALU;
         ST_WB_ALU:   state_d = ST_FETCH;
         ST_MEM_ADDR: state_d = (instr[6:0] == OPC_LOAD) ? ST_MEM_LD : ST_MEM_SD;
         ST_MEM_LD:   if (mem_last) state_d = ST_WB_MEM;
         ST_WB_MEM:   state_d = ST_FETCH;
         ST_MEM_SD:   if (mem_last) state_d = ST_FETCH;
         ST_BRANCH, ST_JALR: state_d = ST_FETCH;
         ST_HALT:     state_d = ST_HALT;
         ST_ILLEGAL:  state_d = ST_ILLEGAL;
         default:     state_d = ST_FETCH;
      endcase
   end

   // Outputs are forced low while reset is asserted, even though the state register holds FETCH.
   always_comb begin
      pc_write      = 1'b0;
      pc_src        = PC_SRC_ALU;
      ir_write      = 1'b0;
      mem_addr_sel  = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mdr_write     = 1'b0;
      ab_write      = 1'b0;
      alu_src_a     = SRC_A_PC;
      alu_src_b     = SRC_B_REG;
      alu_op        = ALU_ADD;
      alu_out_write = 1'b0;
      reg_write     = 1'b0;
      wb_sel        = WB_ALUOUT;
      halted        = 1'b0;
      illegal_op    = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_FETCH: begin
               mem_read = 1'b1;
               if (mem_last) begin
                  ir_write  = 1'b1;
                  pc_write  = 1'b1;
                  pc_src    = PC_SRC_ALU;
                  alu_src_a = SRC_A_PC;
                  alu_src_b = SRC_B_FOUR;
                  alu_op    = ALU_ADD;
               end
            end
            ST_DECODE: begin
               ab_write      = 1'b1;
               alu_out_write = 1'b1;
               alu_src_a     = SRC_A_OLD_PC;
               alu_src_b     = SRC_B_IMM;
            end
            ST_EXEC_R: begin
               alu_src_a     = SRC_A_REG;
               alu_src_b     = SRC_B_REG;
               alu_op        = instr[30] ? ALU_SUB : ALU_ADD;
               alu_out_write = 1'b1;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
               alu_src_a     = SRC_A_REG;
               alu_src_b     = SRC_B_IMM;
               alu_out_write = 1'b1;
            end
            ST_EXEC_LUI: begin
               alu_src_b     = SRC_B_IMM;
               alu_op        = ALU_PASS_B;
               alu_out_write = 1'b1;
            end
            ST_WB_ALU: reg_write = 1'b1;
            ST_MEM_LD: begin
               mem_read     = 1'b1;
               mem_addr_sel = 1'b1;
               mdr_write    = mem_last;
            end
            ST_WB_MEM: begin
               reg_write = 1'b1;
               wb_sel    = WB_MDR;
            end
            ST_MEM_SD: begin
               mem_write    = 1'b1;
               mem_addr_sel = 1'b1;
            end
            ST_BRANCH: begin
               alu_src_a = SRC_A_REG;
               alu_src_b = SRC_B_REG;
               alu_op    = ALU_SUB;
               pc_src    = PC_SRC_ALUOUT;
               pc_write  = alu_zero ^ instr[12];
            end
            ST_JALR: begin
               alu_src_a = SRC_A_REG;
               alu_src_b = SRC_B_IMM;
               pc_write  = 1'b1;
               pc_src    = PC_SRC_JALR;
               reg_write = 1'b1;
               wb_sel    = WB_PC;
            end
            ST_HALT:    halted     = 1'b1;
            ST_ILLEGAL: illegal_op = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - directed self-checking bench for multicycle_ctrl_fsm
module tb_multicycle_ctrl_fsm;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr;
   logic        alu_zero;
   wire  [20:0] o1;
   wire  [20:0] o2;
   int          checks;
   int          errors;

   logic [20:0] v_f0, v_fl, v_dec, v_exi, v_exr_add, v_exr_sub, v_lui, v_wba, v_maddr;
   logic [20:0] v_mld, v_mldl, v_wbm, v_msd, v_brt, v_brn, v_jalr, v_halt, v_ill;

   multicycle_ctrl_fsm #(.MEM_WAIT(1)) dut (
      .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero),
      .pc_write(o1[20]), .pc_src(o1[19:18]), .ir_write(o1[17]), .mem_addr_sel(o1[16]),
      .mem_read(o1[15]), .mem_write(o1[14]), .mdr_write(o1[13]), .ab_write(o1[12]),
      .alu_src_a(o1[11:10]), .alu_src_b(o1[9:8]), .alu_op(o1[7:6]), .alu_out_write(o1[5]),
      .reg_write(o1[4]), .wb_sel(o1[3:2]), .halted(o1[1]), .illegal_op(o1[0])
   );

   multicycle_ctrl_fsm #(.MEM_WAIT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .instr(instr), .alu_zero(alu_zero),
      .pc_write(o2[20]), .pc_src(o2[19:18]), .ir_write(o2[17]), .mem_addr_sel(o2[16]),
      .mem_read(o2[15]), .mem_write(o2[14]), .mdr_write(o2[13]), .ab_write(o2[12]),
      .alu_src_a(o2[11:10]), .alu_src_b(o2[9:8]), .alu_op(o2[7:6]), .alu_out_write(o2[5]),
      .reg_write(o2[4]), .wb_sel(o2[3:2]), .halted(o2[1]), .illegal_op(o2[0])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Field order: pc_write, pc_src, ir_write, mem_addr_sel, mem_read, mem_write, mdr_write,
   // ab_write, alu_src_a, alu_src_b, alu_op, alu_out_write, reg_write, wb_sel, halted, illegal_op
   function automatic logic [20:0] ov(input logic pw, input logic [1:0] ps, input logic irw,
                                      input logic mas, input logic mr, input logic mw,
                                      input logic mdr, input logic ab, input logic [1:0] sa,
                                      input logic [1:0] sb, input logic [1:0] op, input logic aow,
                                      input logic rw, input logic [1:0] wb, input logic h,
                                      input logic il);
      return {pw, ps, irw, mas, mr, mw, mdr, ab, sa, sb, op, aow, rw, wb, h, il};
   endfunction

   task automatic chk(input int which, input logic [20:0] exp, input string tag);
      logic [20:0] obs;
      obs = (which == 2) ? o2 : o1;
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int which, input logic [20:0] exp, input string tag);
      #2;
      chk(which, exp, tag);
      @(negedge clk);
   endtask

   task automatic prog(input logic [31:0] ins, input logic az);
      rst_n    = 1'b0;
      instr    = ins;
      alu_zero = az;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst_n    = 1'b0;
      instr    = 32'h0;
      alu_zero = 1'b0;

      v_f0      = ov(0, 2'd0, 0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 0);
      v_fl      = ov(1, 2'd0, 1, 0, 1, 0, 0, 0, 2'd0, 2'd1, 2'd0, 0, 0, 2'd0, 0, 0);
      v_dec     = ov(0, 2'd0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0, 1, 0, 2'd0, 0, 0);
      v_exi     = ov(0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, 1, 0, 2'd0, 0, 0);
      v_exr_add = ov(0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 1, 0, 2'd0, 0, 0);
      v_exr_sub = ov(0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd1, 1, 0, 2'd0, 0, 0);
      v_lui     = ov(0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 1, 0, 2'd0, 0, 0);
      v_wba     = ov(0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 1, 2'd0, 0, 0);
      v_maddr   = ov(0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, 1, 0, 2'd0, 0, 0);
      v_mld     = ov(0, 2'd0, 0, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 0);
      v_mldl    = ov(0, 2'd0, 0, 1, 1, 0, 1, 0, 2'd0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 0);
      v_wbm     = ov(0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 1, 2'd1, 0, 0);
      v_msd     = ov(0, 2'd0, 0, 1, 0, 1, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 0);
      v_brt     = ov(1, 2'd1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd1, 0, 0, 2'd0, 0, 0);
      v_brn     = ov(0, 2'd1, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd1, 0, 0, 2'd0, 0, 0);
      v_jalr    = ov(1, 2'd2, 0, 0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0, 0, 1, 2'd2, 0, 0);
      v_halt    = ov(0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 2'd0, 1, 0);
      v_ill     = ov(0, 2'd0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 2'd0, 0, 1);

      // Reset, then abort FETCH at cnt=1; FETCH must restart at cnt=0.
      @(negedge clk);
      #2;
      chk(1, 21'h0, "reset_low_dut1");
      chk(2, 21'h0, "reset_low_dut2");
      @(negedge clk);
      rst_n = 1'b1;
      step(1, v_f0, "rst_fetch_c0");
      rst_n = 1'b0;
      #2;
      chk(1, 21'h0, "midfetch_rst_dut1");
      chk(2, 21'h0, "midfetch_rst_dut2");
      @(negedge clk);
      #2;
      chk(1, 21'h0, "midfetch_rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      step(1, v_f0, "post_rst_fetch_c0");
      step(1, v_fl, "post_rst_fetch_last");

      // addi x5,x0,7
      prog(32'h0070_0293, 1'b0);
      step(1, v_f0,  "addi_c1");
      step(1, v_fl,  "addi_c2");
      step(1, v_dec, "addi_c3");
      step(1, v_exi, "addi_c4");
      step(1, v_wba, "addi_c5");
      step(1, v_f0,  "addi_next_fetch");

      // add / sub / lui
      prog(32'h0031_00B3, 1'b0);
      step(1, v_f0, "add_c1"); step(1, v_fl, "add_c2"); step(1, v_dec, "add_c3");
      step(1, v_exr_add, "add_exec"); step(1, v_wba, "add_wb");
      prog(32'h4031_00B3, 1'b0);
      step(1, v_f0, "sub_c1"); step(1, v_fl, "sub_c2"); step(1, v_dec, "sub_c3");
      step(1, v_exr_sub, "sub_exec"); step(1, v_wba, "sub_wb");
      prog(32'h1234_50B7, 1'b0);
      step(1, v_f0, "lui_c1"); step(1, v_fl, "lui_c2"); step(1, v_dec, "lui_c3");
      step(1, v_lui, "lui_exec"); step(1, v_wba, "lui_wb");

      // ld x6,8(x5) at MEM_WAIT=2: 9 cycles
      prog(32'h0082_B303, 1'b0);
      step(2, v_f0,    "ld_w2_c1");
      step(2, v_f0,    "ld_w2_c2");
      step(2, v_fl,    "ld_w2_c3");
      step(2, v_dec,   "ld_w2_c4");
      step(2, v_maddr, "ld_w2_c5");
      step(2, v_mld,   "ld_w2_c6");
      step(2, v_mld,   "ld_w2_c7");
      step(2, v_mldl,  "ld_w2_c8");
      step(2, v_wbm,   "ld_w2_c9");
      step(2, v_f0,    "ld_w2_next_fetch");

      // sd x6,8(x5) at MEM_WAIT=1: 6 cycles
      prog(32'h0062_B423, 1'b0);
      step(1, v_f0, "sd_c1"); step(1, v_fl, "sd_c2"); step(1, v_dec, "sd_c3");
      step(1, v_maddr, "sd_c4"); step(1, v_msd, "sd_c5"); step(1, v_msd, "sd_c6");
      step(1, v_f0, "sd_next_fetch");

      // Branches
      prog(32'h0000_0063, 1'b1);
      step(1, v_f0, "beq_t_c1"); step(1, v_fl, "beq_t_c2"); step(1, v_dec, "beq_t_c3");
      step(1, v_brt, "beq_taken"); step(1, v_f0, "beq_t_fetch");
      prog(32'h0000_1063, 1'b1);
      step(1, v_f0, "bne_c1"); step(1, v_fl, "bne_c2"); step(1, v_dec, "bne_c3");
      step(1, v_brn, "bne_not_taken"); step(1, v_f0, "bne_fetch");
      prog(32'h0000_0063, 1'b0);
      step(1, v_f0, "beq_n_c1"); step(1, v_fl, "beq_n_c2"); step(1, v_dec, "beq_n_c3");
      step(1, v_brn, "beq_not_taken"); step(1, v_f0, "beq_n_fetch");

      // jalr x1,0(x5)
      prog(32'h0002_80E7, 1'b0);
      step(1, v_f0, "jalr_c1"); step(1, v_fl, "jalr_c2"); step(1, v_dec, "jalr_c3");
      step(1, v_jalr, "jalr_exec"); step(1, v_f0, "jalr_fetch");

      // ebreak: halted held for 100 cycles
      prog(32'h0010_0073, 1'b0);
      step(1, v_f0, "ebreak_c1"); step(1, v_fl, "ebreak_c2"); step(1, v_dec, "ebreak_c3");
      for (int i = 0; i < 100; i++) begin
         alu_zero = i[0];
         step(1, v_halt, "ebreak_halted");
      end

      // Near-miss encodings are illegal
      prog(32'h0231_00B3, 1'b0);
      step(1, v_f0, "badf7_c1"); step(1, v_fl, "badf7_c2"); step(1, v_dec, "badf7_c3");
      step(1, v_ill, "badf7_illegal");
      prog(32'h0082_A303, 1'b0);
      step(1, v_f0, "lw_c1"); step(1, v_fl, "lw_c2"); step(1, v_dec, "lw_c3");
      step(1, v_ill, "lw_illegal");

      // 0xFFFFFFFF: sticky illegal_op until reset
      prog(32'hFFFF_FFFF, 1'b0);
      step(1, v_f0, "ill_c1"); step(1, v_fl, "ill_c2"); step(1, v_dec, "ill_c3");
      step(1, v_ill, "ill_enter");
      instr = 32'h0070_0293;
      for (int i = 0; i < 10; i++)
         step(1, v_ill, "ill_sticky");
      rst_n = 1'b0;
      #2;
      chk(1, 21'h0, "ill_reset_low");
      @(negedge clk);
      rst_n = 1'b1;
      step(1, v_f0, "ill_reset_fetch");
      step(1, v_fl, "ill_reset_fetch_last");
      step(1, v_dec, "ill_reset_decode");
      step(1, v_exi, "ill_reset_exec");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
